// File: rtl/mmu_feed_sched_if.sv
// Bundles the control, feeder and writeback signals of mmu_feed_sched.
// The feed_stall input exists only when MMU_FEED_STALL_EN is defined.
interface mmu_feed_sched_if #(
  parameter int DIM = 2
);
  localparam int AW = $clog2(DIM*DIM);

  logic              start;
  logic              busy;
  logic              mmu_clear;
  logic [DIM-1:0]    row_valid;
  logic [DIM*AW-1:0] row_addr;
  logic [DIM-1:0]    col_valid;
  logic [DIM*AW-1:0] col_addr;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic              wb_ready;
  logic              done;
`ifdef MMU_FEED_STALL_EN
  logic              feed_stall;
`endif

  modport master (
`ifdef MMU_FEED_STALL_EN
    input  feed_stall,
`endif
    input  start, wb_ready,
    output busy, mmu_clear, row_valid, row_addr, col_valid, col_addr,
    output wb_valid, wb_addr, done
  );

  modport slave (
`ifdef MMU_FEED_STALL_EN
    output feed_stall,
`endif
    output start, wb_ready,
    input  busy, mmu_clear, row_valid, row_addr, col_valid, col_addr,
    input  wb_valid, wb_addr, done
  );
endinterface

// File: rtl/mmu_feed_sched.sv
// Sequences one DIMxDIM systolic multiply: clear, skewed feed, flush, writeback.
// Optional MMU_FEED_STALL_EN adds feed_stall to pause the FEED/FLUSH schedule.
module mmu_feed_sched #(
  parameter int DIM       = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mmu_feed_sched_if.master bus
);
  localparam int AW = $clog2(DIM*DIM);
  localparam int TW = $clog2(2*DIM-1);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(2*DIM-2);
  localparam logic [FW-1:0] FL_INIT = FW'(FLUSH_CYC-1);
  localparam logic [AW-1:0] R_LAST  = AW'(DIM*DIM-1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_WB} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [FW-1:0]     fl_q, fl_d;
  logic [AW-1:0]     r_q, r_d;
  logic              busy_q, busy_d;
  logic              mmu_clear_q, mmu_clear_d;
  logic [DIM-1:0]    row_valid_q, row_valid_d;
  logic [DIM*AW-1:0] row_addr_q, row_addr_d;
  logic [DIM-1:0]    col_valid_q, col_valid_d;
  logic [DIM*AW-1:0] col_addr_q, col_addr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_addr_q, wb_addr_d;
  logic              done_q, done_d;
  logic              stall, hold, hs;

`ifdef MMU_FEED_STALL_EN
  assign stall = bus.feed_stall;
`else
  assign stall = 1'b0;
`endif

  assign hold = stall & ((state_q == S_FEED) | (state_q == S_FLUSH));
  assign hs   = wb_valid_q & bus.wb_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    fl_d    = fl_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: if (!stall) begin
        if (t_q == T_LAST) begin
          state_d = S_FLUSH;
          fl_d    = FL_INIT;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      // flush counter is a down-counter ending on terminal count 0
      S_FLUSH: if (!stall) begin
        if (fl_q == '0) begin
          state_d = S_WB;
          r_d     = '0;
        end else begin
          fl_d = fl_q - 1'b1;
        end
      end
      S_WB: if (hs) begin
        if (r_q == R_LAST) begin
          state_d = S_IDLE;
          r_d     = '0;
          done_d  = 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they register in step with the state.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    mmu_clear_d = (state_d == S_CLEAR);
    wb_valid_d  = (state_d == S_WB);
    wb_addr_d   = (state_d == S_WB) ? r_d : '0;
    row_valid_d = '0;
    row_addr_d  = '0;
    col_valid_d = '0;
    col_addr_d  = '0;
    if ((state_d == S_FEED) && !hold) begin
      for (int i = 0; i < DIM; i++) begin
        if ((int'(t_d) >= i) && ((int'(t_d) - i) < DIM)) begin
          row_valid_d[i]          = 1'b1;
          row_addr_d[i*AW +: AW]  = AW'(i*DIM + int'(t_d) - i);
          col_valid_d[i]          = 1'b1;
          col_addr_d[i*AW +: AW]  = AW'((int'(t_d) - i)*DIM + i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      fl_q        <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      mmu_clear_q <= 1'b0;
      row_valid_q <= '0;
      row_addr_q  <= '0;
      col_valid_q <= '0;
      col_addr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      fl_q        <= fl_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      mmu_clear_q <= mmu_clear_d;
      row_valid_q <= row_valid_d;
      row_addr_q  <= row_addr_d;
      col_valid_q <= col_valid_d;
      col_addr_q  <= col_addr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mmu_clear = mmu_clear_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_addr  = row_addr_q;
  assign bus.col_valid = col_valid_q;
  assign bus.col_addr  = col_addr_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mmu_feed_sched.sv
// Self-checking bench for mmu_feed_sched: directed scenarios plus random traffic,
// every cycle compared against a phase-level reference model.
module tb_mmu_feed_sched;
  localparam int DIM       = 2;
  localparam int FLUSH_CYC = 2;
  localparam int AW        = $clog2(DIM*DIM);
  localparam int P_IDLE = 0, P_CLEAR = 1, P_FEED = 2, P_FLUSH = 3, P_WB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_drv = 1'b0;
  always #5 clk = ~clk;

  mmu_feed_sched_if #(.DIM(DIM)) bus();
`ifdef MMU_FEED_STALL_EN
  assign bus.feed_stall = stall_drv;
`endif

  mmu_feed_sched #(.DIM(DIM), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_ph = P_IDLE, m_t = 0, m_fl = 0, m_r = 0;
  bit m_done = 0, m_stalled = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_t = 0; m_fl = 0; m_r = 0; m_done = 0; m_stalled = 0;
  endtask

  // one clock edge of the reference: phases and remaining-cycle counts
  task automatic model_step();
    m_done = 0;
    m_stalled = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      P_IDLE:  if (bus.start) m_ph = P_CLEAR;
      P_CLEAR: begin m_ph = P_FEED; m_t = 0; end
      P_FEED: begin
        if (stall_drv) m_stalled = 1;
        else if (m_t == 2*DIM-2) begin m_ph = P_FLUSH; m_fl = FLUSH_CYC; end
        else m_t++;
      end
      P_FLUSH: if (!stall_drv) begin
        m_fl--;
        if (m_fl == 0) begin m_ph = P_WB; m_r = 0; end
      end
      P_WB: if (bus.wb_ready) begin
        if (m_r == DIM*DIM-1) begin m_ph = P_IDLE; m_done = 1; end
        else m_r++;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    logic [DIM-1:0]    erv, ecv;
    logic [DIM*AW-1:0] era, eca;
    int k;
    erv = '0; ecv = '0; era = '0; eca = '0;
    if (m_ph == P_FEED && !m_stalled) begin
      for (int i = 0; i < DIM; i++) begin
        k = m_t - i;
        if (k >= 0 && k < DIM) begin
          erv[i] = 1'b1;
          era[i*AW +: AW] = AW'(i*DIM + k);
          ecv[i] = 1'b1;
          eca[i*AW +: AW] = AW'(k*DIM + i);
        end
      end
    end
    chk("busy",      bus.busy,      m_ph != P_IDLE);
    chk("mmu_clear", bus.mmu_clear, m_ph == P_CLEAR);
    chk("row_valid", bus.row_valid, erv);
    chk("row_addr",  bus.row_addr,  era);
    chk("col_valid", bus.col_valid, ecv);
    chk("col_addr",  bus.col_addr,  eca);
    chk("wb_valid",  bus.wb_valid,  m_ph == P_WB);
    chk("wb_addr",   bus.wb_addr,   (m_ph == P_WB) ? m_r : 0);
    chk("done",      bus.done,      m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_idle();
    int n = 0;
    while ((m_ph != P_IDLE || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int c, lowcnt, dn, dones;
    bit prev_done;
    int acc[$];

    bus.start = 1'b0;
    bus.wb_ready = 1'b0;
    @(negedge clk);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // latency: start sampled at edge 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("clear_cycle1", bus.mmu_clear, 1);
    c = 1;
    while (!bus.wb_valid && c < 30) begin tick(); c++; end
    chk("first_wb_cycle", c, 7);
    chk("first_wb_addr", bus.wb_addr, 0);
    bus.wb_ready = 1'b1;
    run_idle();

    // writeback backpressure at r=1
    bus.wb_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lowcnt = 0; dn = 0; c = 0;
    while (!bus.done && c < 60) begin
      if (bus.wb_valid && bus.wb_addr == 1 && lowcnt < 3) begin
        bus.wb_ready = 1'b0; lowcnt++;
      end else begin
        bus.wb_ready = 1'b1;
      end
      if (bus.wb_valid && bus.wb_ready) acc.push_back(int'(bus.wb_addr));
      tick();
      c++;
      if (bus.done) dn++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) dn++;
    end
    chk("bp_accept_count", acc.size(), DIM*DIM);
    for (int i = 0; i < acc.size(); i++) chk("bp_accept_order", acc[i], i);
    chk("bp_done_count", dn, 1);
    chk("bp_low_cycles", lowcnt, 3);

    // start during FEED and WB is ignored, never queued
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (!bus.done && c < 60) begin
      bus.wb_ready = $urandom_range(0, 1);
      bus.start = (m_ph == P_FEED) || (m_ph == P_WB);
      tick();
      c++;
    end
    bus.start = 1'b0;
    chk("ignored_start_done", bus.done, 1);
    tick();
    chk("no_queued_start", bus.busy, 0);

    // start held high: back-to-back runs
    bus.wb_ready = 1'b1;
    bus.start = 1'b1;
    dones = 0; prev_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (prev_done) chk("b2b_clear_after_done", bus.mmu_clear, 1);
      prev_done = bus.done;
      if (bus.done) begin
        dones++;
        chk("b2b_idle_on_done", bus.busy, 0);
      end
    end
    chk("b2b_runs", dones, 5);
    bus.start = 1'b0;
    run_idle();

    // asynchronous reset in the middle of FEED
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (!(m_ph == P_FEED && m_t == 1) && c < 20) begin tick(); c++; end
    chk("reach_feed_t1", bus.row_valid, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",      bus.busy, 0);
    chk("rst_row_valid", bus.row_valid, 0);
    chk("rst_row_addr",  bus.row_addr, 0);
    chk("rst_col_valid", bus.col_valid, 0);
    chk("rst_col_addr",  bus.col_addr, 0);
    chk("rst_wb_valid",  bus.wb_valid, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fresh_clear", bus.mmu_clear, 1);
    run_idle();

`ifdef MMU_FEED_STALL_EN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 1;
    while (!bus.wb_valid && c < 30) begin
      stall_drv = (m_ph == P_FEED && m_t == 0 && c >= 2 && c < 4);
      tick();
      c++;
    end
    stall_drv = 1'b0;
    chk("stall_first_wb_cycle", c, 9);
    run_idle();
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.wb_ready = $urandom_range(0, 1);
`ifdef MMU_FEED_STALL_EN
      stall_drv = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    bus.start = 1'b0;
    stall_drv = 1'b0;
    bus.wb_ready = 1'b1;
    run_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
